vga_timing_generator: RTL and testbench

//  Pixel-timing front end for the VGA video path. Divides the board clock into a pixel-clock enable,

---
 rtl/vga_timing_generator.sv | 173 +++++++++++++++++
 tb/tb_vga_timing_generator.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_generator.sv
// ---------------------------------------------------------------------------
// vga_timing_generator
//
// Purpose:
//   Pixel-timing front end for the VGA video path. A clock-enable divider
//   produces one pixel_ce pulse every CLK_DIV board clocks. On each pulse the
//   horizontal/vertical counters advance. Registered HSYNC/VSYNC, a visible
//   area flag and a frame_start pulse are derived from the next-state counts,
//   so they line up with pixel_count/line_count in every cycle.
//   Defaults give 800x600@72Hz from a 100 MHz board clock.
//
// Ports:
//   clock        in   system clock (the only clock in the block)
//   reset        in   synchronous, active-high reset
//   pixel_ce     out  one-clock pulse per pixel period
//   pixel_count  out  horizontal position, 0..H_TOTAL-1
//   line_count   out  vertical position, 0..V_TOTAL-1
//   hsync        out  horizontal sync, active level SYNC_POL
//   vsync        out  vertical sync, active level SYNC_POL
//   visible      out  high while the position is inside the visible area
//   frame_start  out  single-clock pulse when the counts enter (0,0)
//   h_vis_start  out  constant H_SYNC+H_BP
//   h_vis_area   out  constant H_VIS
//   v_vis_start  out  constant V_SYNC+V_BP
//   v_vis_area   out  constant V_VIS
//   frame_count  out  16-bit frame counter
//
// Configuration macro:
//   VGA_FRAME_COUNT_EN  when defined, frame_count counts frame_start pulses
//                       (wrapping at 16 bits); otherwise it is tied to zero.
// ---------------------------------------------------------------------------
module vga_timing_generator #(
    parameter int CLK_DIV  = 2,
    parameter int CNT_W    = 11,
    parameter int H_SYNC   = 120,
    parameter int H_BP     = 64,
    parameter int H_VIS    = 800,
    parameter int H_FP     = 56,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 23,
    parameter int V_VIS    = 600,
    parameter int V_FP     = 37,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic             clock,
    input  logic             reset,
    output logic             pixel_ce,
    output logic [CNT_W-1:0] pixel_count,
    output logic [CNT_W-1:0] line_count,
    output logic             hsync,
    output logic             vsync,
    output logic             visible,
    output logic             frame_start,
    output logic [CNT_W-1:0] h_vis_start,
    output logic [CNT_W-1:0] h_vis_area,
    output logic [CNT_W-1:0] v_vis_start,
    output logic [CNT_W-1:0] v_vis_area,
    output logic [15:0]      frame_count
);

    localparam int H_TOTAL = H_SYNC + H_BP + H_VIS + H_FP;
    localparam int V_TOTAL = V_SYNC + V_BP + V_VIS + V_FP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_VIS_BEG  = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] H_VIS_END  = CNT_W'(H_SYNC + H_BP + H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_BEG  = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] V_VIS_END  = CNT_W'(V_SYNC + V_BP + V_VIS);

    // Totals must fit the counters, otherwise the wrap compares never match.
    if (H_TOTAL >= (2 ** CNT_W) || V_TOTAL >= (2 ** CNT_W)) begin : g_cnt_too_narrow
        $error("vga_timing_generator: H_TOTAL/V_TOTAL do not fit in CNT_W bits");
    end

    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic             pixel_ce_q, pixel_ce_d;
    logic [CNT_W-1:0] pixel_count_q, pixel_count_d;
    logic [CNT_W-1:0] line_count_q, line_count_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             visible_q, visible_d;
    logic             frame_start_q, frame_start_d;
    logic             tick;

    // The divider's last phase is the tick: the registered pixel_ce goes high
    // on the following edge, and the counters advance on that same edge.
    always_comb begin
        tick          = (div_cnt_q == DIV_LAST);
        div_cnt_d     = tick ? '0 : div_cnt_q + 1'b1;
        pixel_ce_d    = tick;
        pixel_count_d = pixel_count_q;
        line_count_d  = line_count_q;
        if (tick) begin
            if (pixel_count_q == H_LAST) begin
                pixel_count_d = '0;
                line_count_d  = (line_count_q == V_LAST) ? '0 : line_count_q + 1'b1;
            end else begin
                pixel_count_d = pixel_count_q + 1'b1;
            end
        end
        // Decoding next-state counts keeps sync/visible aligned with the counts.
        hsync_d       = (pixel_count_d < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        vsync_d       = (line_count_d < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        visible_d     = (pixel_count_d >= H_VIS_BEG) && (pixel_count_d < H_VIS_END) &&
                        (line_count_d >= V_VIS_BEG) && (line_count_d < V_VIS_END);
        // Only the transition into (0,0) counts, not the idle clocks spent there.
        frame_start_d = tick && (pixel_count_q == H_LAST) && (line_count_q == V_LAST);
    end

    // Reset parks the counters on the last front-porch position so the first
    // pixel_ce after release lands exactly on (0,0).
    always_ff @(posedge clock) begin
        if (reset) begin
            div_cnt_q     <= '0;
            pixel_ce_q    <= 1'b0;
            pixel_count_q <= H_LAST;
            line_count_q  <= V_LAST;
            hsync_q       <= ~SYNC_POL;
            vsync_q       <= ~SYNC_POL;
            visible_q     <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            div_cnt_q     <= div_cnt_d;
            pixel_ce_q    <= pixel_ce_d;
            pixel_count_q <= pixel_count_d;
            line_count_q  <= line_count_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            visible_q     <= visible_d;
            frame_start_q <= frame_start_d;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [15:0] frame_count_q, frame_count_d;

    // Counts frames in the same clock that frame_start is raised; wraps at 16 bits.
    always_comb begin
        frame_count_d = frame_start_d ? frame_count_q + 16'd1 : frame_count_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            frame_count_q <= 16'h0000;
        end else begin
            frame_count_q <= frame_count_d;
        end
    end

    assign frame_count = frame_count_q;
`else
    assign frame_count = 16'h0000;
`endif

    assign pixel_ce    = pixel_ce_q;
    assign pixel_count = pixel_count_q;
    assign line_count  = line_count_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign visible     = visible_q;
    assign frame_start = frame_start_q;

    assign h_vis_start = H_VIS_BEG;
    assign h_vis_area  = CNT_W'(H_VIS);
    assign v_vis_start = V_VIS_BEG;
    assign v_vis_area  = CNT_W'(V_VIS);

endmodule

// File: tb/tb_vga_timing_generator.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_generator
//
// Three instances run side by side on one clock and one reset:
//   A  default 800x600@72Hz timing
//   B  small frame (10x8 positions, CLK_DIV=2, positive sync) so whole
//      frames, wraps and frame spacing fit in a short run
//   C  same small frame with CLK_DIV=1 and negative sync
// Every clock, the expected outputs of each instance are computed from a
// closed-form position model (clocks since reset release) and queued; the
// queue is popped and compared on the falling edge.
// ---------------------------------------------------------------------------
module tb_vga_timing_generator;

    typedef struct {
        int clk_div;
        int h_sync, h_bp, h_vis, h_fp;
        int v_sync, v_bp, v_vis, v_fp;
        bit pol;
    } cfg_t;

    typedef struct {
        logic [31:0] pixel_ce, pixel, line, hsync, vsync, visible, frame_start, frame_count;
    } obs_t;

    typedef struct {
        int clk;
        int px;
        int ln;
        bit hs;
        bit vs;
        bit vis;
        bit fs;
        int fc;
    } vec_t;

`ifdef VGA_FRAME_COUNT_EN
    localparam int FC_ON = 1;
`else
    localparam int FC_ON = 0;
`endif

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    logic        a_pixel_ce, a_hsync, a_vsync, a_visible, a_frame_start;
    logic [10:0] a_pixel_count, a_line_count, a_h_vis_start, a_h_vis_area, a_v_vis_start, a_v_vis_area;
    logic [15:0] a_frame_count;
    logic        b_pixel_ce, b_hsync, b_vsync, b_visible, b_frame_start;
    logic [7:0]  b_pixel_count, b_line_count, b_h_vis_start, b_h_vis_area, b_v_vis_start, b_v_vis_area;
    logic [15:0] b_frame_count;
    logic        c_pixel_ce, c_hsync, c_vsync, c_visible, c_frame_start;
    logic [7:0]  c_pixel_count, c_line_count, c_h_vis_start, c_h_vis_area, c_v_vis_start, c_v_vis_area;
    logic [15:0] c_frame_count;

    vga_timing_generator dut_a (
        .clock(clock), .reset(reset), .pixel_ce(a_pixel_ce),
        .pixel_count(a_pixel_count), .line_count(a_line_count),
        .hsync(a_hsync), .vsync(a_vsync), .visible(a_visible), .frame_start(a_frame_start),
        .h_vis_start(a_h_vis_start), .h_vis_area(a_h_vis_area),
        .v_vis_start(a_v_vis_start), .v_vis_area(a_v_vis_area), .frame_count(a_frame_count)
    );

    vga_timing_generator #(
        .CLK_DIV(2), .CNT_W(8), .H_SYNC(3), .H_BP(2), .H_VIS(4), .H_FP(1),
        .V_SYNC(2), .V_BP(1), .V_VIS(3), .V_FP(2), .SYNC_POL(1'b1)
    ) dut_b (
        .clock(clock), .reset(reset), .pixel_ce(b_pixel_ce),
        .pixel_count(b_pixel_count), .line_count(b_line_count),
        .hsync(b_hsync), .vsync(b_vsync), .visible(b_visible), .frame_start(b_frame_start),
        .h_vis_start(b_h_vis_start), .h_vis_area(b_h_vis_area),
        .v_vis_start(b_v_vis_start), .v_vis_area(b_v_vis_area), .frame_count(b_frame_count)
    );

    vga_timing_generator #(
        .CLK_DIV(1), .CNT_W(8), .H_SYNC(3), .H_BP(2), .H_VIS(4), .H_FP(1),
        .V_SYNC(2), .V_BP(1), .V_VIS(3), .V_FP(2), .SYNC_POL(1'b0)
    ) dut_c (
        .clock(clock), .reset(reset), .pixel_ce(c_pixel_ce),
        .pixel_count(c_pixel_count), .line_count(c_line_count),
        .hsync(c_hsync), .vsync(c_vsync), .visible(c_visible), .frame_start(c_frame_start),
        .h_vis_start(c_h_vis_start), .h_vis_area(c_h_vis_area),
        .v_vis_start(c_v_vis_start), .v_vis_area(c_v_vis_area), .frame_count(c_frame_count)
    );

    cfg_t cfgs[3];
    obs_t expQ[3][$];
    int   total = 0;
    int   bad = 0;
    int   printed = 0;
    int   t = 0;
    int   cyc = 0;
    int   lastFs[3];
    int   visCnt[3];
    int   fsSpacing[3];
    int   spacingChecks = 0;

    // Expected outputs after t clocks since reset release (t=0 is the reset state).
    function automatic obs_t model(cfg_t c, int tt);
        obs_t m;
        int ht, vt, frame, n, idx, px, ln;
        ht    = c.h_sync + c.h_bp + c.h_vis + c.h_fp;
        vt    = c.v_sync + c.v_bp + c.v_vis + c.v_fp;
        frame = ht * vt;
        n     = tt / c.clk_div;
        idx   = (n + frame - 1) % frame;
        px    = idx % ht;
        ln    = idx / ht;
        m.pixel_ce    = 32'((tt >= 1) && (tt % c.clk_div == 0));
        m.pixel       = 32'(px);
        m.line        = 32'(ln);
        m.hsync       = 32'((px < c.h_sync) ? c.pol : !c.pol);
        m.vsync       = 32'((ln < c.v_sync) ? c.pol : !c.pol);
        m.visible     = 32'((px >= c.h_sync + c.h_bp) && (px < c.h_sync + c.h_bp + c.h_vis) &&
                            (ln >= c.v_sync + c.v_bp) && (ln < c.v_sync + c.v_bp + c.v_vis));
        m.frame_start = 32'((m.pixel_ce == 32'd1) && (idx == 0));
        m.frame_count = (n == 0) ? 32'd0 : 32'(FC_ON * ((((n - 1) / frame) + 1) % 65536));
        return m;
    endfunction

    function automatic obs_t getObs(int id);
        obs_t o;
        case (id)
            0: begin
                o.pixel_ce = 32'(a_pixel_ce); o.pixel = 32'(a_pixel_count); o.line = 32'(a_line_count);
                o.hsync = 32'(a_hsync); o.vsync = 32'(a_vsync); o.visible = 32'(a_visible);
                o.frame_start = 32'(a_frame_start); o.frame_count = 32'(a_frame_count);
            end
            1: begin
                o.pixel_ce = 32'(b_pixel_ce); o.pixel = 32'(b_pixel_count); o.line = 32'(b_line_count);
                o.hsync = 32'(b_hsync); o.vsync = 32'(b_vsync); o.visible = 32'(b_visible);
                o.frame_start = 32'(b_frame_start); o.frame_count = 32'(b_frame_count);
            end
            default: begin
                o.pixel_ce = 32'(c_pixel_ce); o.pixel = 32'(c_pixel_count); o.line = 32'(c_line_count);
                o.hsync = 32'(c_hsync); o.vsync = 32'(c_vsync); o.visible = 32'(c_visible);
                o.frame_start = 32'(c_frame_start); o.frame_count = 32'(c_frame_count);
            end
        endcase
        return o;
    endfunction

    task automatic compareVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (printed < 40) begin
                printed++;
                $display("[TB] FAIL %s at t=%0d: got %0d, expected %0d", name, t, act, exp);
            end
        end
    endtask

    // Pops the queued expectation of every instance and compares all outputs.
    task automatic checkOutput();
        obs_t e, o;
        string p;
        for (int id = 0; id < 3; id++) begin
            e = expQ[id].pop_front();
            o = getObs(id);
            p = (id == 0) ? "A" : ((id == 1) ? "B" : "C");
            compareVal({p, ".pixel_ce"}, o.pixel_ce, e.pixel_ce);
            compareVal({p, ".pixel_count"}, o.pixel, e.pixel);
            compareVal({p, ".line_count"}, o.line, e.line);
            compareVal({p, ".hsync"}, o.hsync, e.hsync);
            compareVal({p, ".vsync"}, o.vsync, e.vsync);
            compareVal({p, ".visible"}, o.visible, e.visible);
            compareVal({p, ".frame_start"}, o.frame_start, e.frame_start);
            compareVal({p, ".frame_count"}, o.frame_count, e.frame_count);
            // Frame spacing and visible-pixel count, from observed pulses only.
            if (o.frame_start === 32'd1) begin
                if (lastFs[id] >= 0) begin
                    compareVal({p, ".frame_spacing"}, 32'(cyc - lastFs[id]), 32'(fsSpacing[id]));
                    compareVal({p, ".visible_pixels"}, 32'(visCnt[id]), (id == 0) ? 32'd480000 : 32'd12);
                    spacingChecks++;
                end
                lastFs[id] = cyc;
                visCnt[id] = 0;
            end
            if (o.pixel_ce === 32'd1 && o.visible === 32'd1) visCnt[id]++;
        end
    endtask

    task automatic stepClock();
        @(posedge clock);
        if (reset) begin
            t = 0;
            for (int id = 0; id < 3; id++) begin
                lastFs[id] = -1;
                visCnt[id] = 0;
            end
        end else begin
            t++;
        end
        cyc++;
        for (int id = 0; id < 3; id++) expQ[id].push_back(model(cfgs[id], t));
        @(negedge clock);
        checkOutput();
    endtask

    task automatic applyStimulus(input bit rst, input int cycles);
        reset = rst;
        for (int i = 0; i < cycles; i++) stepClock();
    endtask

    vec_t vecs[11];

    initial begin
        cfgs[0] = '{2, 120, 64, 800, 56, 6, 23, 600, 37, 1'b1};
        cfgs[1] = '{2, 3, 2, 4, 1, 2, 1, 3, 2, 1'b1};
        cfgs[2] = '{1, 3, 2, 4, 1, 2, 1, 3, 2, 1'b0};
        fsSpacing[0] = 1385280;
        fsSpacing[1] = 160;
        fsSpacing[2] = 80;
        for (int id = 0; id < 3; id++) begin
            lastFs[id] = -1;
            visCnt[id] = 0;
        end

        // Instance B, first frame after release: {clk, px, ln, hs, vs, vis, fs, frame_count}.
        vecs[0]  = '{3,   0, 0, 1'b1, 1'b1, 1'b0, 1'b0, FC_ON};
        vecs[1]  = '{12,  5, 0, 1'b0, 1'b1, 1'b0, 1'b0, FC_ON};
        vecs[2]  = '{62,  0, 3, 1'b1, 1'b0, 1'b0, 1'b0, FC_ON};
        vecs[3]  = '{70,  4, 3, 1'b0, 1'b0, 1'b0, 1'b0, FC_ON};
        vecs[4]  = '{72,  5, 3, 1'b0, 1'b0, 1'b1, 1'b0, FC_ON};
        vecs[5]  = '{78,  8, 3, 1'b0, 1'b0, 1'b1, 1'b0, FC_ON};
        vecs[6]  = '{80,  9, 3, 1'b0, 1'b0, 1'b0, 1'b0, FC_ON};
        vecs[7]  = '{112, 5, 5, 1'b0, 1'b0, 1'b1, 1'b0, FC_ON};
        vecs[8]  = '{132, 5, 6, 1'b0, 1'b0, 1'b0, 1'b0, FC_ON};
        vecs[9]  = '{160, 9, 7, 1'b0, 1'b0, 1'b0, 1'b0, FC_ON};
        vecs[10] = '{162, 0, 0, 1'b1, 1'b1, 1'b0, 1'b1, 2 * FC_ON};

        // Reset held for three clocks, then released.
        applyStimulus(1'b1, 3);
        compareVal("A.h_vis_start", 32'(a_h_vis_start), 32'd184);
        compareVal("A.h_vis_area", 32'(a_h_vis_area), 32'd800);
        compareVal("A.v_vis_start", 32'(a_v_vis_start), 32'd29);
        compareVal("A.v_vis_area", 32'(a_v_vis_area), 32'd600);
        compareVal("B.h_vis_start", 32'(b_h_vis_start), 32'd5);
        compareVal("B.v_vis_start", 32'(b_v_vis_start), 32'd3);
        compareVal("A.reset_pixel", 32'(a_pixel_count), 32'd1039);
        compareVal("A.reset_line", 32'(a_line_count), 32'd665);

        // First clock after release: nothing moves yet.
        applyStimulus(1'b0, 1);
        compareVal("A.clk1_pixel_ce", 32'(a_pixel_ce), 32'd0);
        compareVal("A.clk1_pixel", 32'(a_pixel_count), 32'd1039);
        compareVal("C.clk1_pixel_ce", 32'(c_pixel_ce), 32'd1);
        compareVal("C.clk1_frame_start", 32'(c_frame_start), 32'd1);
        // Second clock: first pixel, frame start at (0,0).
        applyStimulus(1'b0, 1);
        compareVal("A.clk2_pixel_ce", 32'(a_pixel_ce), 32'd1);
        compareVal("A.clk2_pixel", 32'(a_pixel_count), 32'd0);
        compareVal("A.clk2_line", 32'(a_line_count), 32'd0);
        compareVal("A.clk2_frame_start", 32'(a_frame_start), 32'd1);
        compareVal("A.clk2_hsync", 32'(a_hsync), 32'd1);
        compareVal("A.clk2_vsync", 32'(a_vsync), 32'd1);
        compareVal("A.clk2_visible", 32'(a_visible), 32'd0);

        // Table-driven checks on instance B through its first wrap.
        for (int i = 0; i < 11; i++) begin
            for (int guard = 0; guard < 1000 && t < vecs[i].clk; guard++) stepClock();
            compareVal("B.vec_clk", 32'(t), 32'(vecs[i].clk));
            compareVal("B.vec_pixel", 32'(b_pixel_count), 32'(vecs[i].px));
            compareVal("B.vec_line", 32'(b_line_count), 32'(vecs[i].ln));
            compareVal("B.vec_hsync", 32'(b_hsync), 32'(vecs[i].hs));
            compareVal("B.vec_vsync", 32'(b_vsync), 32'(vecs[i].vs));
            compareVal("B.vec_visible", 32'(b_visible), 32'(vecs[i].vis));
            compareVal("B.vec_frame_start", 32'(b_frame_start), 32'(vecs[i].fs));
            compareVal("B.vec_frame_count", 32'(b_frame_count), 32'(vecs[i].fc));
        end

        // Default timing through the first two lines: hsync edge at pixel 120 of line 1.
        while (t < 2320) stepClock();
        compareVal("A.line1_px119_hsync", 32'(a_hsync), 32'd1);
        compareVal("A.line1_px119_pixel", 32'(a_pixel_count), 32'd119);
        applyStimulus(1'b0, 2);
        compareVal("A.line1_px120_hsync", 32'(a_hsync), 32'd0);
        compareVal("A.line1_px120_line", 32'(a_line_count), 32'd1);
        while (t < 4401) stepClock();

        // One-clock reset mid-frame returns every instance to the reset position.
        applyStimulus(1'b1, 1);
        compareVal("A.midrst_pixel", 32'(a_pixel_count), 32'd1039);
        compareVal("A.midrst_line", 32'(a_line_count), 32'd665);
        compareVal("A.midrst_hsync", 32'(a_hsync), 32'd0);
        compareVal("A.midrst_vsync", 32'(a_vsync), 32'd0);
        compareVal("A.midrst_pixel_ce", 32'(a_pixel_ce), 32'd0);
        compareVal("B.midrst_pixel", 32'(b_pixel_count), 32'd9);
        compareVal("B.midrst_line", 32'(b_line_count), 32'd7);
        compareVal("C.midrst_hsync", 32'(c_hsync), 32'd1);
        applyStimulus(1'b0, 1);
        compareVal("B.post_rst1_frame_start", 32'(b_frame_start), 32'd0);
        applyStimulus(1'b0, 1);
        compareVal("A.post_rst2_frame_start", 32'(a_frame_start), 32'd1);
        compareVal("B.post_rst2_frame_start", 32'(b_frame_start), 32'd1);
        compareVal("A.post_rst2_frame_count", 32'(a_frame_count), 32'(FC_ON));

        // Several more small frames to exercise spacing after the reset.
        applyStimulus(1'b0, 400);
        compareVal("spacing_checks_seen", 32'(spacingChecks >= 4), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
